// File: rtl/rr_arbiter_8.sv
// rr_arbiter_8 -- eight-way round-robin arbiter for a shared 32-bit adder.
// A grant is held for a whole transaction and released when the holder drops
// its request; every release is followed by exactly one idle (dead) cycle.
// Optional feature macro: ARB_TIMEOUT_EN -- when defined, a hold counter
// preempts a holder after MAX_HOLD consecutive grant cycles and pulses preempt.
module rr_arbiter_8 #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       preempt
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic       gnt_valid_q, gnt_valid_d;

  logic       win_found_s;
  logic [2:0] win_idx_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] MAX_HOLD_C = 8'(MAX_HOLD);

  logic [7:0] hold_q, hold_d;
  logic       preempt_q, preempt_d;
`else
  // MAX_HOLD has no effect when the timeout is not built.
  logic [7:0] max_hold_unused_s;
  assign max_hold_unused_s = 8'(MAX_HOLD);
`endif

  // Round-robin search: scan from ptr upward (mod 8); the lowest scan offset
  // with a set request wins, so iterate from the far end and let it overwrite.
  always_comb begin
    win_found_s = |req;
    win_idx_s   = ptr_q;
    for (int i = 7; i >= 0; i--) begin
      win_idx_s = req[3'(ptr_q + 3'(i))] ? 3'(ptr_q + 3'(i)) : win_idx_s;
    end
  end

  // Next-state logic for the IDLE/GRANT machine and all registered outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    preempt_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (win_found_s) begin
          state_d     = GRANT;
          gnt_idx_d   = win_idx_s;
          gnt_d       = 8'h01 << win_idx_s;
          gnt_valid_d = 1'b1;
          ptr_d       = 3'(win_idx_s + 3'd1);
`ifdef ARB_TIMEOUT_EN
          hold_d      = 8'd1;
`endif
        end else begin
          gnt_d       = 8'h00;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q]) begin
          // Holder finished: a drop on the timeout cycle is a normal release.
          state_d     = IDLE;
          gnt_d       = 8'h00;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
          hold_d      = 8'd0;
        end else if (hold_q == MAX_HOLD_C) begin
          // Holder overstayed; ptr already points past it, so others go first.
          state_d     = IDLE;
          gnt_d       = 8'h00;
          gnt_idx_d   = 3'd0;
          gnt_valid_d = 1'b0;
          hold_d      = 8'd0;
          preempt_d   = 1'b1;
`endif
        end else begin
          state_d = GRANT;
`ifdef ARB_TIMEOUT_EN
          hold_d  = (hold_q == 8'hFF) ? hold_q : 8'(hold_q + 8'd1);
`endif
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_d       = 8'h00;
        gnt_idx_d   = 3'd0;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= 3'd0;
      gnt_q       <= 8'h00;
      gnt_idx_q   <= 3'd0;
      gnt_valid_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= 8'd0;
      preempt_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
`ifdef ARB_TIMEOUT_EN
      hold_q      <= hold_d;
      preempt_q   <= preempt_d;
`endif
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = gnt_idx_q;
  assign gnt_valid = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
  assign preempt   = preempt_q;
`else
  assign preempt   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Testbench for rr_arbiter_8: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_rr_arbiter_8;

  localparam int MAXH = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       preempt;

  int tests_run    = 0;
  int tests_failed = 0;

  // Behavioural model: who holds the adder, where the next search starts,
  // how long the holder has held it, and whether the last edge preempted.
  int m_ptr    = 0;
  int m_holder = -1;
  int m_hold   = 0;
  bit m_pre    = 1'b0;

  rr_arbiter_8 #(.MAX_HOLD(MAXH)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid),
    .preempt  (preempt)
  );

  always #5 clk = ~clk;

  task automatic model_edge(input logic [7:0] r, input logic rs);
    if (rs) begin
      m_ptr = 0; m_holder = -1; m_hold = 0; m_pre = 1'b0;
    end else if (m_holder < 0) begin
      m_pre = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (m_holder < 0 && r[(m_ptr + i) % 8]) begin
          m_holder = (m_ptr + i) % 8;
        end
      end
      if (m_holder >= 0) begin
        m_ptr  = (m_holder + 1) % 8;
        m_hold = 1;
      end
    end else if (!r[m_holder]) begin
      m_holder = -1; m_hold = 0; m_pre = 1'b0;
    end else if (TO_EN && m_hold == MAXH) begin
      m_holder = -1; m_hold = 0; m_pre = 1'b1;
    end else begin
      m_hold = (m_hold < 255) ? m_hold + 1 : 255;
      m_pre  = 1'b0;
    end
  endtask

  function automatic logic [12:0] model_vec();
    logic [7:0] g;
    logic [2:0] ix;
    g  = (m_holder < 0) ? 8'h00 : (8'h01 << m_holder);
    ix = (m_holder < 0) ? 3'd0 : 3'(m_holder);
    return {g, ix, (m_holder >= 0), m_pre};
  endfunction

  task automatic tick();
    model_edge(req, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== 13'h0000) begin
        tests_failed++;
        $display("FAIL reset_state: got gnt=%h idx=%0d v=%b pre=%b, want all zero",
                 gnt, gnt_idx, gnt_valid, preempt);
      end
    end
    rst = 1'b0; req = 8'hFF;
    tick();
    tests_run++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0 || gnt_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_priority: got gnt=%h idx=%0d v=%b, want gnt=01 idx=0 v=1",
               gnt, gnt_idx, gnt_valid);
    end
  endtask

  task automatic test_rotation();
    int cur;
    int nxt;
    cur = 0;
    for (int k = 1; k <= 8; k++) begin
      nxt = k % 8;
      req = 8'hFF;
      tick(); tick();
      req = 8'hFF & ~(8'h01 << cur);
      tick();
      tests_run++;
      if (gnt !== 8'h00 || gnt_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL rotation_dead_cycle: after release of %0d got gnt=%h v=%b, want 00/0",
                 cur, gnt, gnt_valid);
      end
      req = 8'hFF;
      tick();
      tests_run++;
      if (gnt !== (8'h01 << nxt) || gnt_idx !== 3'(nxt)) begin
        tests_failed++;
        $display("FAIL rotation_order: got gnt=%h idx=%0d, want idx=%0d", gnt, gnt_idx, nxt);
      end
      cur = nxt;
    end
  endtask

  task automatic test_wraparound();
    req = 8'h00; tick();
    req = 8'h40; tick();
    tests_run++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      tests_failed++;
      $display("FAIL wrap_setup: got gnt=%h idx=%0d, want 40/6", gnt, gnt_idx);
    end
    req = 8'h01; tick();
    req = 8'h41; tick();
    tests_run++;
    if (gnt !== 8'h01 || gnt_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL wraparound: got gnt=%h idx=%0d, want 01/0", gnt, gnt_idx);
    end
  endtask

  task automatic test_noninterference();
    req = 8'h00; tick();
    req = 8'h08; tick();
    tests_run++;
    if (gnt !== 8'h08) begin
      tests_failed++;
      $display("FAIL nonint_grant: got gnt=%h, want 08", gnt);
    end
    req = 8'h88;
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (gnt !== 8'h08 || gnt_idx !== 3'd3) begin
        tests_failed++;
        $display("FAIL nonint_hold: cycle %0d got gnt=%h, want 08", c, gnt);
      end
    end
    req = 8'h80; tick();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0) begin
      tests_failed++;
      $display("FAIL nonint_release: got gnt=%h v=%b pre=%b, want 00/0/0", gnt, gnt_valid, preempt);
    end
    tick();
    tests_run++;
    if (gnt !== 8'h80 || gnt_idx !== 3'd7) begin
      tests_failed++;
      $display("FAIL nonint_next: got gnt=%h idx=%0d, want 80/7", gnt, gnt_idx);
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    req = 8'h00; tick();
    req = 8'h05; tick();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (gnt !== 8'h01 || preempt !== 1'b0) begin
        tests_failed++;
        $display("FAIL timeout_hold: cycle %0d got gnt=%h pre=%b, want 01/0", c, gnt, preempt);
      end
    end
    tick();
    tests_run++;
    if (gnt !== 8'h00 || preempt !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout_preempt: got gnt=%h pre=%b, want 00/1", gnt, preempt);
    end
    tick();
    tests_run++;
    if (gnt !== 8'h04 || preempt !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_next: got gnt=%h pre=%b, want 04/0", gnt, preempt);
    end
    req = 8'h00; tick();
    req = 8'h01; tick();
    tick(); tick(); tick();
    tick();
    tests_run++;
    if (preempt !== 1'b1 || gnt_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_alone_preempt: got pre=%b v=%b, want 1/0", preempt, gnt_valid);
    end
    tick();
    tests_run++;
    if (gnt !== 8'h01 || preempt !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_regrant: got gnt=%h pre=%b, want 01/0", gnt, preempt);
    end
    tick(); tick(); tick();
    req = 8'h00; tick();
    tests_run++;
    if (gnt !== 8'h00 || preempt !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_simul_release: got gnt=%h pre=%b, want 00/0", gnt, preempt);
    end
  endtask
`endif

  task automatic test_reset_midgrant();
    req = 8'h00; tick();
    req = 8'h20; tick();
    tests_run++;
    if (gnt !== 8'h20) begin
      tests_failed++;
      $display("FAIL midrst_setup: got gnt=%h, want 20", gnt);
    end
    rst = 1'b1; tick();
    tests_run++;
    if (gnt !== 8'h00 || gnt_valid !== 1'b0 || preempt !== 1'b0 || gnt_idx !== 3'd0) begin
      tests_failed++;
      $display("FAIL midrst_drop: got gnt=%h v=%b pre=%b idx=%0d, want zero",
               gnt, gnt_valid, preempt, gnt_idx);
    end
    rst = 1'b0; tick();
    tests_run++;
    if (gnt !== 8'h20 || gnt_idx !== 3'd5) begin
      tests_failed++;
      $display("FAIL midrst_regrant: got gnt=%h idx=%0d, want 20/5", gnt, gnt_idx);
    end
    req = 8'h00; tick();
    req = 8'hFF; tick();
    tests_run++;
    if (gnt !== 8'h40 || gnt_idx !== 3'd6) begin
      tests_failed++;
      $display("FAIL midrst_ptr: got gnt=%h idx=%0d, want 40/6", gnt, gnt_idx);
    end
  endtask

  task automatic test_random();
    logic [12:0] exp_v;
    int fails_here;
    fails_here = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       req = 8'($urandom());
        1:       req = req ^ (8'h01 << $urandom_range(0, 7));
        2:       req = req;
        default: req = (m_holder >= 0 && $urandom_range(0, 1) == 0)
                       ? (req & ~(8'h01 << m_holder)) : req;
      endcase
      rst = ($urandom_range(0, 255) == 0);
      tick();
      exp_v = model_vec();
      tests_run++;
      if ({gnt, gnt_idx, gnt_valid, preempt} !== exp_v) begin
        tests_failed++;
        fails_here++;
        if (fails_here <= 10)
          $display("FAIL random_model: cycle %0d req=%h got gnt=%h idx=%0d v=%b pre=%b, want gnt=%h idx=%0d v=%b pre=%b",
                   c, req, gnt, gnt_idx, gnt_valid, preempt,
                   exp_v[12:5], exp_v[4:2], exp_v[1], exp_v[0]);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_wraparound();
    test_noninterference();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_midgrant();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
